// File: rtl/sram_bit_slice.sv
// rtl/sram_bit_slice.sv - behavioural SRAM bit slice: write driver, storage cell, sense amp
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   row_wr     in   write wordline
//   row_rd     in   read wordline
//   data_in    in   real level to store (1 when >= VTH)
//   bl_wr      out  write bitline (real)
//   blb_wr     out  complementary write bitline (real)
//   bl_rd      out  read bitline (real)
//   blb_rd     out  complementary read bitline (real)
//   preout     out  sensed level, VDD or VSS (real)
//   dout       out  digital form of preout
//   dout_valid out  one-cycle pulse per completed read
module sram_bit_slice #(
    parameter real VDD = 1.5,
    parameter real VSS = 0.0,
    parameter real VTH = 0.8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic row_wr,
    input  logic row_rd,
    input  real  data_in,
    output real  bl_wr,
    output real  blb_wr,
    output real  bl_rd,
    output real  blb_rd,
    output real  preout,
    output logic dout,
    output logic dout_valid
);

    logic q_q;
    logic q_d;
    real  preout_q;
    real  preout_d;
    logic dout_q;
    logic dout_d;
    logic dout_valid_q;
    logic dout_valid_d;

    // Write driver runs continuously; the wordline only gates the cell update.
    always_comb begin
        if (data_in >= VTH) begin
            bl_wr  = VDD;
            blb_wr = VSS;
        end else begin
            bl_wr  = VSS;
            blb_wr = VDD;
        end
    end

    // Read bitlines sit precharged high until the read wordline opens the cell.
    always_comb begin
        if (!row_rd) begin
            bl_rd  = VDD;
            blb_rd = VDD;
        end else if (q_q) begin
            bl_rd  = VDD;
            blb_rd = VSS;
        end else begin
            bl_rd  = VSS;
            blb_rd = VDD;
        end
    end

    // Cell only flips on a complementary bitline pair; anything else holds.
    always_comb begin
        q_d = q_q;
        if (row_wr) begin
            if (bl_wr > VTH && blb_wr < VTH) begin
                q_d = 1'b1;
            end else if (bl_wr < VTH && blb_wr > VTH) begin
                q_d = 1'b0;
            end
        end
    end

    // Sense amp resolves from the pre-edge bitlines, so a same-edge write
    // is not visible to the read (read-before-write).
    always_comb begin
        preout_d     = preout_q;
        dout_valid_d = 1'b0;
        if (row_rd) begin
            dout_valid_d = 1'b1;
            if ((bl_rd - blb_rd) > 0.0) begin
                preout_d = VDD;
            end else if ((bl_rd - blb_rd) < 0.0) begin
                preout_d = VSS;
            end
        end
        dout_d = (preout_d == VDD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q          <= 1'b0;
            preout_q     <= VSS;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            preout_q     <= preout_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign preout     = preout_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sram_bit_slice.sv
// tb/tb_sram_bit_slice.sv - self-checking bench for sram_bit_slice
module tb_sram_bit_slice;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    logic clk;
    logic rst_n;
    logic row_wr;
    logic row_rd;
    real  data_in;
    real  bl_wr;
    real  blb_wr;
    real  bl_rd;
    real  blb_rd;
    real  preout;
    logic dout;
    logic dout_valid;

    int checks;
    int failures;

    // Reference state: the stored bit and the last sensed level.
    bit  m_bit;
    real m_pre;
    bit  m_valid;

    sram_bit_slice #(.VDD(VDD), .VSS(VSS), .VTH(VTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_wr    (row_wr),
        .row_rd    (row_rd),
        .data_in   (data_in),
        .bl_wr     (bl_wr),
        .blb_wr    (blb_wr),
        .bl_rd     (bl_rd),
        .blb_rd    (blb_rd),
        .preout    (preout),
        .dout      (dout),
        .dout_valid(dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0.3f exp=%0.3f", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check the
    // combinational bitlines, clock, then check the sensed outputs.
    task automatic step(input bit rst, input bit wr, input bit rd, input real din);
        @(negedge clk);
        rst_n   = rst;
        row_wr  = wr;
        row_rd  = rd;
        data_in = din;
        #1;
        check("bl_wr",  bl_wr,  (din >= VTH) ? VDD : VSS);
        check("blb_wr", blb_wr, (din >= VTH) ? VSS : VDD);
        check("bl_rd",  bl_rd,  (rd && !m_bit) ? VSS : VDD);
        check("blb_rd", blb_rd, (rd &&  m_bit) ? VSS : VDD);
        @(posedge clk);
        if (!rst) begin
            m_bit   = 1'b0;
            m_pre   = VSS;
            m_valid = 1'b0;
        end else begin
            m_valid = rd;
            if (rd) m_pre = m_bit ? VDD : VSS;
            if (wr) m_bit = (din >= VTH);
        end
        #1;
        check("preout",     preout,           m_pre);
        check("dout",       real'(dout),       (m_pre == VDD) ? 1.0 : 0.0);
        check("dout_valid", real'(dout_valid), m_valid ? 1.0 : 0.0);
    endtask

    initial begin
        real din;
        checks   = 0;
        failures = 0;
        m_bit    = 1'b0;
        m_pre    = VSS;
        m_valid  = 1'b0;
        rst_n    = 1'b0;
        row_wr   = 1'b0;
        row_rd   = 1'b0;
        data_in  = 0.0;

        // Reset held for two edges
        step(0, 0, 0, 0.0);
        step(0, 0, 0, 0.0);

        // Write 1 then read, then idle to see the pulse drop
        step(1, 1, 0, 1.5);
        step(1, 0, 1, 1.5);
        step(1, 0, 0, 0.0);

        // Write 0 then read
        step(1, 1, 0, 0.0);
        step(1, 0, 1, 0.0);

        // Threshold boundary
        step(1, 1, 0, 0.79);
        step(1, 0, 1, 0.0);
        step(1, 1, 0, 0.8);
        step(1, 0, 1, 0.0);

        // Simultaneous write 0 / read with q = 1, then a follow-up read
        step(1, 1, 1, 0.0);
        step(1, 0, 1, 0.0);

        // Reset during a read with q = 1, then read after reset
        step(1, 1, 0, 1.5);
        step(1, 0, 1, 1.5);
        step(0, 0, 1, 1.5);
        step(1, 0, 1, 1.5);

        // Multi-cycle read gives consecutive pulses
        step(1, 1, 0, 1.5);
        step(1, 0, 1, 0.0);
        step(1, 0, 1, 0.0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: din = 0.79;
                1: din = 0.8;
                default: din = real'($urandom_range(0, 150)) / 100.0;
            endcase
            step(($urandom_range(0, 15) != 0), $urandom_range(0, 1), $urandom_range(0, 1), din);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bit_slice.md
# sram_bit_slice

Behavioural mixed-signal model of one SRAM bit slice: a write driver, a single 6T-style storage cell with separate write and read bitline pairs, and a differential sense amplifier. It converts a real-valued input level into a stored bit and returns that bit as a rail-level real voltage plus a digital flag. It is the leaf element that column and array wrappers instantiate once per bit, and it is used as the reference model for the analog cell characterization flow.

## Interface
Parameters:
- VDD, 1.5, supply rail in volts, real.
- VSS, 0.0, ground rail in volts, real.
- VTH, 0.8, logic decision threshold in volts, real.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- row_wr  input  1  write wordline; a write occurs on a rising clk edge while high.
- row_rd  input  1  read wordline; a read occurs on a rising clk edge while high.
- data_in  input  real  level to be written; logic 1 if data_in >= VTH, else logic 0.
- bl_wr  output  real  write bitline, driven by the write driver.
- blb_wr  output  real  complementary write bitline.
- bl_rd  output  real  read bitline.
- blb_rd  output  real  complementary read bitline.
- preout  output  real  sense-amp output level, VDD or VSS.
- dout  output  1  digital form of preout (1 when preout == VDD).
- dout_valid  output  1  one-cycle pulse marking a completed read.

## Operation
- Write driver, combinational: bl_wr = VDD and blb_wr = VSS when data_in >= VTH; otherwise bl_wr = VSS and blb_wr = VDD. It drives continuously, independent of row_wr and reset.
- Cell: the storage bit `q` is updated on a rising clk edge when rst_n = 1 and row_wr = 1.
  - If bl_wr > VTH and blb_wr < VTH, q <= 1.
  - If bl_wr < VTH and blb_wr > VTH, q <= 0.
  - Any non-complementary bitline pair, such as both high or both low, leaves q unchanged.
- Read bitlines, combinational:
  - When row_rd = 0, both bl_rd and blb_rd are precharged to VDD.
  - When row_rd = 1 and q = 1, bl_rd = VDD and blb_rd = VSS.
  - When row_rd = 1 and q = 0, bl_rd = VSS and blb_rd = VDD.
- Sense amp: on a rising clk edge with rst_n = 1 and row_rd = 1:
  - preout <= VDD if (bl_rd − blb_rd) > 0, preout <= VSS if (bl_rd − blb_rd) < 0.
  - If the difference is 0, preout holds its value.
  - dout follows preout.
  - dout_valid <= 1 for that cycle; otherwise dout_valid <= 0.
- Between reads, preout and dout hold the last sensed value.
- Simultaneous row_wr and row_rd on the same edge: the read senses the old q (read-before-write), and q takes the new value.
- Reset (rst_n = 0 at a rising edge): q <= 0, preout <= VSS, dout <= 0, dout_valid <= 0. Writes and reads in that cycle are ignored.
- Reset overrides any in-progress row_wr or row_rd.

## Timing
- Write latency: q is updated on the first rising edge at which row_wr = 1. Holding row_wr across several edges rewrites the same value; this is harmless.
- Read latency: the read bitlines respond combinationally to row_rd. preout, dout and dout_valid are valid one edge after row_rd is first sampled high.
- A read on edge N+1 following a write on edge N returns the newly written value.
- dout_valid pulses on every edge at which row_rd is sampled high. A multi-cycle row_rd therefore gives consecutive pulses.
- No handshake or back-pressure exists; every qualifying edge is a completed operation.

## Test plan
- Reset: hold rst_n = 0 for 2 edges. Required: preout = 0.0, dout = 0, dout_valid = 0, and bl_rd = blb_rd = 1.5 with row_rd = 0.
- Write 1 then read: data_in = 1.5, row_wr = 1 for one edge, then row_rd = 1 for one edge. Required: bl_wr = 1.5 and blb_wr = 0.0 immediately. During the read, bl_rd = 1.5 and blb_rd = 0.0. After the read edge, preout = 1.5, dout = 1 and dout_valid pulses once.
- Write 0 then read: data_in = 0.0, write, then read. Required: blb_rd = 1.5 and bl_rd = 0.0 during the read, then preout = 0.0 and dout = 0.
- Threshold boundary:
  - data_in = 0.79 writes 0 and reads back preout = 0.0.
  - data_in = 0.8 writes 1 and reads back preout = 1.5.
- Simultaneous access: with q = 1, apply data_in = 0.0 with row_wr = row_rd = 1 on one edge. Required: preout = 1.5 after that edge. A following read gives preout = 0.0.
- Reset mid-operation: with q = 1, assert rst_n = 0 on an edge where row_rd = 1. Required: preout = 0.0 and dout_valid = 0. A read after reset returns preout = 0.0.
